// File: rtl/aes_pkg.sv
// Shared AES types for the sequential InvSubBytes block: the 128-bit state,
// the column geometry, the FSM states and column get/set helpers.
package aes_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 32;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Column 0 is the most significant word, [127:96].
    function automatic logic [COL_W-1:0] get_col(aes_state_t s, logic [1:0] k);
        return s[(NUM_COLS - 1 - int'(k)) * COL_W +: COL_W];
    endfunction

    function automatic aes_state_t set_col(aes_state_t s, logic [1:0] k, logic [COL_W-1:0] v);
        aes_state_t r;
        r = s;
        r[(NUM_COLS - 1 - int'(k)) * COL_W +: COL_W] = v;
        return r;
    endfunction

endpackage

// File: rtl/inv_sbox_sync.sv
// FIPS-197 inverse S-box with a registered output: the address is sampled on
// the rising edge and the substituted byte appears one cycle later.
module inv_sbox_sync (
    input  logic       int_osc,
    input  logic       nreset,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // NOTE: the table is a constant ROM and is never reset; only the output register is.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb begin
        data_d = INV_SBOX[addr];
    end

    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/inv_subbytes_seq.sv
// Sequential InvSubBytes: four inverse S-boxes process one 32-bit column per
// cycle; a start accepted in IDLE yields a one-cycle done pulse six cycles later.
module inv_subbytes_seq
    import aes_pkg::*;
(
    input  logic       int_osc,
    input  logic       nreset,
    input  logic       start,
    input  aes_state_t state_in,
    output aes_state_t state_out,
    output logic       busy,
    output logic       done
);

    fsm_state_e fsm_d,    fsm_q;
    logic [2:0] cnt_d,    cnt_q;
    aes_state_t src_d,    src_q;
    aes_state_t out_d,    out_q;
    logic       wr_en_d,  wr_en_q;
    logic [1:0] wr_col_d, wr_col_q;
    logic       busy_d,   busy_q;
    logic       done_d,   done_q;

    logic [COL_W-1:0] sbox_addr;
    logic [COL_W-1:0] sbox_col;

    for (genvar g = 0; g < NUM_COLS; g++) begin : g_sbox
        inv_sbox_sync u_inv_sbox (
            .int_osc (int_osc),
            .nreset  (nreset),
            .addr    (sbox_addr[8*g +: 8]),
            .data    (sbox_col[8*g +: 8])
        );
    end

    // Counter value 4 is the drain step and must never address the S-boxes.
    always_comb begin
        sbox_addr = '0;
        if (fsm_q == RUN && cnt_q < 3'(NUM_COLS)) begin
            sbox_addr = get_col(src_q, cnt_q[1:0]);
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        src_d    = src_q;
        wr_en_d  = 1'b0;
        wr_col_d = wr_col_q;
        out_d    = wr_en_q ? set_col(out_q, wr_col_q, sbox_col) : out_q;

        unique case (fsm_q)
            IDLE: begin
                if (start) begin
                    fsm_d = RUN;
                    src_d = state_in;
                    cnt_d = '0;
                end
            end
            RUN: begin
                if (cnt_q < 3'(NUM_COLS)) begin
                    wr_en_d  = 1'b1;
                    wr_col_d = cnt_q[1:0];
                    cnt_d    = cnt_q + 3'd1;
                end else begin
                    fsm_d = DONE;
                end
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase

        busy_d = (fsm_d != IDLE);
        done_d = (fsm_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            fsm_q    <= IDLE;
            cnt_q    <= '0;
            src_q    <= '0;
            out_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_col_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            out_q    <= out_d;
            wr_en_q  <= wr_en_d;
            wr_col_q <= wr_col_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign state_out = out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq: reference S-boxes are derived from GF(2^8)
// arithmetic, and results are compared per scenario against that model.
module tb_inv_subbytes_seq;
    import aes_pkg::*;

    logic       int_osc = 1'b0;
    logic       nreset  = 1'b0;
    logic       start   = 1'b0;
    aes_state_t state_in = '0;
    aes_state_t state_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_subbytes_seq dut (
        .int_osc   (int_osc),
        .nreset    (nreset),
        .start     (start),
        .state_in  (state_in),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 int_osc = ~int_osc;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box = affine(multiplicative inverse); inverse table by inversion.
    task automatic build_tables();
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            fwd_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic aes_state_t model_inv(aes_state_t s);
        aes_state_t r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic aes_state_t model_fwd(aes_state_t s);
        aes_state_t r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_tab[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic aes_state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept at E0, wait (bounded) for done, capture the result, step back to IDLE.
    // lat counts edges after E0 until done is seen; latency in cycles is lat+1.
    task automatic do_op(input aes_state_t din, output aes_state_t dout,
                         output int lat, output bit ok, output bit busy_ok);
        state_in = din;
        start    = 1'b1;
        @(posedge int_osc); #1;
        start   = 1'b0;
        lat     = 0;
        ok      = 1'b0;
        busy_ok = 1'b1;
        dout    = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge int_osc); #1;
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        dout = state_out;
        @(posedge int_osc); #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge int_osc);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (state_out !== '0) begin n_fail++; $display("FAIL reset_state_out: got %h expected 0", state_out); end
        #2 nreset = 1'b1;
        @(posedge int_osc); #1;
    endtask

    task automatic test_all_63();
        aes_state_t din, got;
        int lat;
        bit ok, bok;
        din = {16{8'h63}};
        do_op(din, got, lat, ok, bok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL all63_done: no done within bound"); end
        n_checks++;
        if (lat + 1 != 6) begin n_fail++; $display("FAIL all63_latency: got %0d cycles expected 6", lat + 1); end
        n_checks++;
        if (!bok) begin n_fail++; $display("FAIL all63_busy: busy low during transform"); end
        n_checks++;
        if (got !== 128'h0) begin n_fail++; $display("FAIL all63_result: got %h expected 0", got); end
    endtask

    task automatic test_known_vector();
        aes_state_t got, expv;
        int lat;
        bit ok, bok;
        expv = 128'h000102030405060708090a0b0c0d0e0f;
        do_op(128'h637c777bf26b6fc53001672bfed7ab76, got, lat, ok, bok);
        n_checks++;
        if (!ok || lat + 1 != 6) begin
            n_fail++;
            $display("FAIL known_latency: done=%b cycles=%0d expected 6", ok, lat + 1);
        end
        n_checks++;
        if (got !== expv) begin n_fail++; $display("FAIL known_result: got %h expected %h", got, expv); end
        n_checks++;
        if (got !== model_inv(128'h637c777bf26b6fc53001672bfed7ab76)) begin
            n_fail++;
            $display("FAIL known_model: got %h expected %h", got, model_inv(128'h637c777bf26b6fc53001672bfed7ab76));
        end
    endtask

    task automatic test_input_change();
        aes_state_t din, expv, held;
        bit ok;
        din  = {8'h16, 8'hed, {14{8'h63}}};
        expv = {8'hff, 8'h53, 112'h0};
        ok   = 1'b0;
        state_in = din;
        start    = 1'b1;
        @(posedge int_osc); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            state_in = rand_state();
            @(posedge int_osc); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        held = state_out;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL change_done: no done within bound"); end
        n_checks++;
        if (held !== expv) begin n_fail++; $display("FAIL change_result: got %h expected %h", held, expv); end
        n_checks++;
        if (held !== model_inv(din)) begin n_fail++; $display("FAIL change_model: got %h expected %h", held, model_inv(din)); end
        repeat (4) begin
            state_in = rand_state();
            @(posedge int_osc); #1;
        end
        n_checks++;
        if (state_out !== expv) begin n_fail++; $display("FAIL hold_after_done: got %h expected %h", state_out, expv); end
    endtask

    task automatic test_start_held();
        aes_state_t a, b, res0, res1;
        int pos [$];
        bit busy_gap_ok;
        a = rand_state();
        b = rand_state();
        res0 = '0;
        res1 = '0;
        busy_gap_ok = 1'b0;
        state_in = a;
        start    = 1'b1;
        @(posedge int_osc); #1;
        state_in = b;
        for (int i = 1; i <= 20; i++) begin
            @(posedge int_osc); #1;
            if (i == 13) start = 1'b0;
            if (i == 6 && busy === 1'b0) busy_gap_ok = 1'b1;
            if (done) begin
                if (pos.size() == 0) res0 = state_out;
                else if (pos.size() == 1) res1 = state_out;
                pos.push_back(i);
            end
        end
        n_checks++;
        if (pos.size() != 2) begin n_fail++; $display("FAIL held_done_count: got %0d expected 2", pos.size()); end
        n_checks++;
        if (pos.size() < 2 || pos[0] != 5 || pos[1] != 12) begin
            n_fail++;
            $display("FAIL held_done_pos: got %p expected 5 and 12", pos);
        end
        n_checks++;
        if (!busy_gap_ok) begin n_fail++; $display("FAIL held_idle_gap: busy not low in IDLE cycle after DONE"); end
        n_checks++;
        if (res0 !== model_inv(a)) begin n_fail++; $display("FAIL held_first: got %h expected %h", res0, model_inv(a)); end
        n_checks++;
        if (res1 !== model_inv(b)) begin n_fail++; $display("FAIL held_second: got %h expected %h", res1, model_inv(b)); end
    endtask

    task automatic test_reset_mid_run();
        aes_state_t din, got;
        int lat;
        bit ok, bok, spurious;
        din = {8'h52, rand_state() >> 8};
        state_in = din;
        start    = 1'b1;
        @(posedge int_osc); #1;
        start = 1'b0;
        repeat (3) @(posedge int_osc);
        #1 nreset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
        n_checks++;
        if (state_out !== '0) begin n_fail++; $display("FAIL midreset_state_out: got %h expected 0", state_out); end
        #2 nreset = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge int_osc); #1;
            if (done || busy) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) begin n_fail++; $display("FAIL midreset_no_done: activity after aborted transform"); end
        din = rand_state();
        do_op(din, got, lat, ok, bok);
        n_checks++;
        if (!ok || lat + 1 != 6 || got !== model_inv(din)) begin
            n_fail++;
            $display("FAIL midreset_restart: done=%b cycles=%0d got %h expected %h", ok, lat + 1, got, model_inv(din));
        end
    endtask

    task automatic test_round_trip();
        aes_state_t p, got;
        int lat;
        bit ok, bok;
        for (int v = 0; v < 1000; v++) begin
            p = rand_state();
            do_op(model_fwd(p), got, lat, ok, bok);
            n_checks++;
            if (!ok || lat + 1 != 6 || !bok || got !== p) begin
                n_fail++;
                $display("FAIL round_trip[%0d]: done=%b cycles=%0d got %h expected %h", v, ok, lat + 1, got, p);
            end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_all_63();
        test_known_vector();
        test_input_change();
        test_start_held();
        test_reset_mid_run();
        test_round_trip();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
